// File: rtl/fpcmp_pkg.sv
// Shared widths, sequencer states and predicate encodings for the fpcmp run/stall interface.
package fpcmp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned PRED_W = 2;
    localparam int unsigned RSP_W  = 1 + FLAG_W;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    // Predicate codes understood by fpcmp; the sequencer forwards them untouched.
    typedef enum logic [PRED_W-1:0] {
        PredEq,
        PredLt,
        PredLe,
        PredUn
    } pred_e;

    function automatic logic [RSP_W-1:0] pack_rsp(input logic z, input logic [FLAG_W-1:0] flags);
        return {z, flags};
    endfunction

endpackage

// File: rtl/fpcmp_seq_fifo.sv
// Synchronous FIFO with flop storage; head is read straight from the storage registers.
module fpcmp_seq_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (cnt_q != '0);
    assign count      = cnt_q;

endmodule

// File: rtl/fpcmp_seq.sv
// Request/response sequencer that drives an fpcmp unit over its run/stall handshake.
module fpcmp_seq
    import fpcmp_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PRED_W-1:0] req_pred,
    input  logic [FP_W-1:0]   req_x,
    input  logic [FP_W-1:0]   req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_z,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              run,
    input  logic              stall,
    output logic [PRED_W-1:0] pred,
    output logic [FP_W-1:0]   x,
    output logic [FP_W-1:0]   y,
    input  logic              z,
    input  logic [FLAG_W-1:0] flags,
    output logic              timeout_err,
    output logic [15:0]       op_count
);

    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    state_e           state;
    logic [TW-1:0]    timer;
    logic             push_q;
    logic [RSP_W-1:0] cap_q;
    logic [RSP_W-1:0] head;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      used;

    // A captured result waits one cycle in cap_q before entering the FIFO, so it still
    // holds a reserved slot while push_q is set.
    assign used      = {1'b0, fifo_count} + (CW + 1)'(push_q);
    assign req_ready = (state == StIdle) && (used < (CW + 1)'(RSP_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            run         <= 1'b0;
            pred        <= '0;
            x           <= '0;
            y           <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            op_count    <= '0;
            push_q      <= 1'b0;
            cap_q       <= '0;
        end else begin
            push_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        pred  <= req_pred;
                        x     <= req_x;
                        y     <= req_y;
                        run   <= 1'b1;
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    timer <= '0;
                    state <= StWait;
                end
                StWait: begin
                    if (!stall) begin
                        cap_q    <= pack_rsp(z, flags);
                        push_q   <= 1'b1;
                        op_count <= op_count + 16'd1;
                        run      <= 1'b0;
                        state    <= StIdle;
                    end else if (timer == TIMER_MAX) begin
                        run         <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    fpcmp_seq_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_q),
        .push_data  (cap_q),
        .pop        (rsp_valid && rsp_ready),
        .head_data  (head),
        .head_valid (rsp_valid),
        .count      (fifo_count)
    );

    assign rsp_z     = head[FLAG_W];
    assign rsp_flags = head[FLAG_W-1:0];

endmodule

// File: tb/tb_fpcmp_seq.sv
// Directed bench for fpcmp_seq with a behavioural fpcmp model (programmable stall per op).
module tb_fpcmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_pred;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_z;
    logic [4:0]  rsp_flags;
    logic        run;
    logic        stall;
    logic [1:0]  pred;
    logic [31:0] x;
    logic [31:0] y;
    logic        z;
    logic [4:0]  flags;
    logic        timeout_err;
    logic [15:0] op_count;

    int vectors = 0;
    int miscompares = 0;

    // fpcmp model controls
    bit         use_fn = 1'b0;
    logic       z_m = 1'b0;
    logic [4:0] flags_m = '0;
    int         stall_cfg = 0;
    int         wstall = 0;
    int         wcnt = 0;
    logic       prev_run = 1'b0;

    // pump state
    logic [5:0]  exp_q[$];
    int          acc_cnt;
    int          pop_cnt;
    logic [1:0]  cur_pred;
    logic [31:0] cur_x;
    logic [31:0] cur_y;
    int          cur_stall;

    fpcmp_seq #(
        .RSP_DEPTH (4),
        .TIMEOUT   (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pred    (req_pred),
        .req_x       (req_x),
        .req_y       (req_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_z       (rsp_z),
        .rsp_flags   (rsp_flags),
        .run         (run),
        .stall       (stall),
        .pred        (pred),
        .x           (x),
        .y           (y),
        .z           (z),
        .flags       (flags),
        .timeout_err (timeout_err),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic zf(input logic [1:0] p, input logic [31:0] a, input logic [31:0] b);
        return a[7] ^ b[3] ^ p[0];
    endfunction

    function automatic logic [4:0] ff(input logic [1:0] p, input logic [31:0] a,
                                      input logic [31:0] b);
        return a[4:0] ^ b[9:5] ^ {3'b000, p};
    endfunction

    // Stall count is latched at the accept edge; stall counts WAIT cycles after ISSUE.
    always @(posedge clk) begin
        prev_run <= run;
        if (req_valid && req_ready) wstall <= stall_cfg;
        if (run && !prev_run) wcnt <= 0;
        else if (run) wcnt <= wcnt + 1;
    end

    assign stall = run && prev_run && ((wstall < 0) || (wcnt < wstall));
    assign z     = use_fn ? zf(pred, x, y) : z_m;
    assign flags = use_fn ? ff(pred, x, y) : flags_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic regen(input bit rnd);
        cur_x     = $urandom;
        cur_y     = $urandom;
        cur_pred  = 2'($urandom_range(0, 3));
        cur_stall = rnd ? int'($urandom_range(0, 3)) : 0;
    endtask

    // Offers requests until acc_lim accepted and takes responses until pop_lim popped.
    task automatic pump(input int ncyc, input int acc_lim, input int pop_lim, input bit rnd);
        bit acc;
        bit pop;
        for (int c = 0; c < ncyc; c++) begin
            if (acc_cnt >= acc_lim && pop_cnt >= pop_lim) break;
            req_valid = (acc_cnt < acc_lim);
            req_pred  = cur_pred;
            req_x     = cur_x;
            req_y     = cur_y;
            stall_cfg = cur_stall;
            rsp_ready = (pop_cnt < pop_lim) && (!rnd || $urandom_range(0, 1) == 1);
            #1;
            acc = req_valid && req_ready;
            pop = rsp_valid && rsp_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_order", 32'({rsp_z, rsp_flags}), 32'(exp_q.pop_front()));
                end
            end
            tick();
            if (pop) pop_cnt++;
            if (acc) begin
                exp_q.push_back({zf(cur_pred, cur_x, cur_y), ff(cur_pred, cur_x, cur_y)});
                acc_cnt++;
                regen(rnd);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        int run_cyc;
        bit saw_rsp;

        rst = 1'b1;
        req_valid = 1'b0;
        req_pred = '0;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Single op, no stall
        use_fn = 1'b0;
        z_m = 1'b1;
        flags_m = 5'h00;
        stall_cfg = 0;
        req_valid = 1'b1;
        req_pred = 2'd2;
        req_x = 32'h3F80_0000;
        req_y = 32'h4000_0000;
        tick();
        req_valid = 1'b0;
        chk("single_issue_run", 32'(run), 32'd1);
        chk("single_issue_x", x, 32'h3F80_0000);
        chk("single_issue_y", y, 32'h4000_0000);
        chk("single_issue_pred", 32'(pred), 32'd2);
        chk("single_issue_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_wait_run", 32'(run), 32'd1);
        chk("single_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_done_run", 32'(run), 32'd0);
        chk("single_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("single_op_count", 32'(op_count), 32'd1);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_z", 32'(rsp_z), 32'd1);
        chk("single_rsp_flags", 32'(rsp_flags), 32'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_popped", 32'(rsp_valid), 32'd0);

        // Five stall cycles with invalid flag passed through
        z_m = 1'b0;
        flags_m = 5'h10;
        stall_cfg = 5;
        req_valid = 1'b1;
        req_pred = 2'd1;
        req_x = 32'hC040_0000;
        req_y = 32'h3F00_0000;
        chk("stall_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 7; c++) begin
            if (run !== 1'b1 || x !== 32'hC040_0000 || y !== 32'h3F00_0000 || pred !== 2'd1
                || rsp_valid !== 1'b0) bad++;
            tick();
        end
        chk("stall_hold_bad_cycles", 32'(bad), 32'd0);
        chk("stall_done_run", 32'(run), 32'd0);
        chk("stall_op_count", 32'(op_count), 32'd2);
        tick();
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_z", 32'(rsp_z), 32'd0);
        chk("stall_rsp_flags", 32'(rsp_flags), 32'h10);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: depth 4, six requests offered
        do_reset();
        use_fn = 1'b1;
        acc_cnt = 0;
        pop_cnt = 0;
        exp_q.delete();
        regen(1'b0);
        pump(40, 6, 0, 1'b0);
        chk("bp_accepted", 32'(acc_cnt), 32'd4);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        pump(40, 6, 1, 1'b0);
        chk("bp_accepted_after_pop", 32'(acc_cnt), 32'd5);
        pump(200, 6, 6, 1'b0);
        chk("bp_popped", 32'(pop_cnt), 32'd6);
        chk("bp_op_count", 32'(op_count), 32'd6);
        chk("bp_queue_left", 32'(exp_q.size()), 32'd0);

        // Timeout with stall stuck high
        do_reset();
        stall_cfg = -1;
        req_valid = 1'b1;
        req_pred = 2'd3;
        req_x = 32'h7FC0_0000;
        req_y = 32'h0000_0001;
        tick();
        req_valid = 1'b0;
        run_cyc = 0;
        saw_rsp = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (run === 1'b1) run_cyc++;
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
            tick();
        end
        chk("to_run_cycles", 32'(run_cyc), 32'd65);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_no_rsp", 32'(saw_rsp), 32'd0);
        chk("to_op_count", 32'(op_count), 32'd0);
        acc_cnt = 0;
        pop_cnt = 0;
        exp_q.delete();
        regen(1'b0);
        pump(50, 1, 1, 1'b0);
        chk("to_recover_pop", 32'(pop_cnt), 32'd1);
        chk("to_recover_op_count", 32'(op_count), 32'd1);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a stalled WAIT, with a result parked in the FIFO
        pump(50, 2, 1, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        chk("mid_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        stall_cfg = -1;
        req_valid = 1'b1;
        req_pred = 2'd0;
        req_x = 32'h1234_5678;
        req_y = 32'h9ABC_DEF0;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("mid_pre_run", 32'(run), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_run", 32'(run), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_op_count", 32'(op_count), 32'd0);
        chk("mid_timeout_err", 32'(timeout_err), 32'd0);
        chk("mid_x", x, 32'd0);

        // 100 back-to-back ops, random stall 0..3 and random rsp_ready
        acc_cnt = 0;
        pop_cnt = 0;
        exp_q.delete();
        regen(1'b1);
        pump(5000, 100, 100, 1'b1);
        chk("rnd_accepted", 32'(acc_cnt), 32'd100);
        chk("rnd_popped", 32'(pop_cnt), 32'd100);
        chk("rnd_op_count", 32'(op_count), 32'd100);
        chk("rnd_queue_left", 32'(exp_q.size()), 32'd0);
        tick();
        chk("rnd_rsp_valid_end", 32'(rsp_valid), 32'd0);
        chk("rnd_timeout_err", 32'(timeout_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpcmp_seq.md
Name: fpcmp_seq

Overview:
- Hardware initiator for the run/stall floating-point compare interface.
- Takes compare requests (predicate, x, y) from a valid/ready request channel and drives run/pred/x/y into an fpcmp instance.
- Holds operands stable while the unit stalls, then captures z/flags into a small result FIFO drained over a valid/ready response channel.
- Sits between a command source (CPU coprocessor port or test sequencer) and fpcmp, replacing software-driven stepping.

Parameters:
- RSP_DEPTH, 4, result FIFO entries (power of two, >= 2).
- TIMEOUT, 64, consecutive WAIT cycles with stall=1 before abort (>= 2).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle.
- req_pred  input  2  compare predicate.
- req_x  input  32  operand x (IEEE single).
- req_y  input  32  operand y.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer takes head.
- rsp_z  output  1  compare result at head.
- rsp_flags  output  5  exception flags at head.
- run  output  1  to fpcmp.
- stall  input  1  from fpcmp.
- pred  output  2  to fpcmp.
- x  output  32  to fpcmp.
- y  output  32  to fpcmp.
- z  input  1  from fpcmp.
- flags  input  5  from fpcmp.
- timeout_err  output  1  sticky; set on abort.
- op_count  output  16  completed operations, wraps at 2^16.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state=IDLE, run=0, pred/x/y=0, FIFO emptied, rsp_valid=0, timeout_err=0, op_count=0, stall timer=0.
- req_ready is combinational: 1 iff state==IDLE and FIFO occupancy + in-flight < RSP_DEPTH. There is at most one in-flight operation, so accept requires occupancy <= RSP_DEPTH-1. A slot is always reserved, so capture never overflows.
- IDLE:
  - On req_valid & req_ready: latch req_pred/x/y into pred/x/y, run<=1, go ISSUE.
- ISSUE (one cycle):
  - run=1 with stable operands; fpcmp samples at this cycle's edge.
  - Go WAIT, stall timer<=0.
- WAIT:
  - run stays 1, operands unchanged.
  - stall==0: push {z,flags} into FIFO, op_count+1, run<=0, go IDLE.
  - stall==1: timer+1.
  - Timer reaching TIMEOUT-1 while stall==1: run<=0, timeout_err<=1, nothing pushed, op_count unchanged, go IDLE.
- Throughput and latency:
  - Minimum 3 cycles per op (IDLE accept, ISSUE, WAIT).
  - rsp_valid rises 3 edges after the accept edge when stall is never asserted.
- FIFO:
  - Head registered outputs, pointer wrap modulo RSP_DEPTH.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop in one cycle: occupancy unchanged, data order preserved.
  - rsp_z/rsp_flags hold last head value when empty (don't-care, but X-free).
- Flags pass through unchanged; no interpretation of pred.
- timeout_err is cleared only by rst.

Decomposition:
- Shared package fpcmp_pkg:
  - constants FP_W=32, FLAG_W=5, PRED_W=2.
  - state enum {IDLE, ISSUE, WAIT}.
  - predicate encodings used by fpcmp.
- One natural sub-module: fpcmp_seq_fifo, a parametric synchronous FIFO (width 6, depth RSP_DEPTH) with count output used for req_ready.

Test Plan:
- Single op, model fpcmp with stall=0:
  - req pred=2, x=3F800000, y=40000000; fpcmp model returns z=1, flags=00.
  - Expect run high exactly 2 cycles, rsp_valid 3 edges after accept, rsp_z=1, rsp_flags=00, op_count=1.
- Stall 5 cycles:
  - Expect x/y/pred constant and run=1 for all 7 cycles.
  - Capture on first stall=0; flags=10 (invalid) passed through as rsp_flags=10.
- Backpressure, rsp_ready=0, RSP_DEPTH=4, 6 requests offered:
  - Expect exactly 4 accepted, req_ready=0 afterward.
  - After draining one entry, the 5th is accepted; order of results matches issue order.
- Timeout, stall held at 1, TIMEOUT=64:
  - Expect run drops after 64 WAIT cycles, timeout_err=1, no rsp_valid, op_count=0.
  - Next request is still accepted and completes normally.
- Reset mid-WAIT (stall=1):
  - Assert rst one cycle.
  - Expect next edge run=0, state IDLE, FIFO empty, counters and timeout_err zero.
- Back-to-back 100 ops with random stall 0-3 and random rsp_ready:
  - Results match a reference model queue; op_count=100; no drop or duplication.
